alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready request port and a registered result port.
// Single-cycle ops complete in one cycle; MUL is an iterative shift-add over WIDTH cycles.
module alu_mc #(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               op,
  input  logic [WIDTH-1:0]         src0,
  input  logic [WIDTH-1:0]         src1,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         dst,
  output logic                     ov,
  output logic                     zr,
  output logic                     neg,
  output logic                     err
);

  localparam int H  = WIDTH / 2;
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_NOR = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_LHB = 4'd8;
  localparam logic [3:0] OP_LLB = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT             r_state;
  stateT             w_stateNext;
  logic [WIDTH-1:0]  r_dst;
  logic              r_ov;
  logic              r_zr;
  logic              r_neg;
  logic              r_err;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [SW-1:0]     r_cnt;

  logic              w_accept;
  logic              w_isMul;
  logic              w_mulLast;
  logic [WIDTH-1:0]  w_sum;
  logic [WIDTH-1:0]  w_diff;
  logic [WIDTH-1:0]  w_sra;
  logic [WIDTH-1:0]  w_accNext;
  logic [WIDTH-1:0]  w_res;
  logic              w_ov;
  logic              w_zr;
  logic              w_neg;
  logic              w_err;

  assign w_accept  = in_valid && in_ready;
  assign w_isMul   = (MUL_EN != 0) && (op == OP_MUL);
  assign w_mulLast = (r_state == BUSY) && (r_cnt == LAST);
  assign w_sum     = src0 + src1;
  assign w_diff    = src0 - src1;
  assign w_sra     = WIDTH'($signed(src0) >>> shamt);
  assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);

  assign dst = r_dst;
  assign ov  = r_ov;
  assign zr  = r_zr;
  assign neg = r_neg;
  assign err = r_err;

  // Single-cycle result path, evaluated on the live request operands.
  always_comb begin
    w_res = '0;
    w_ov  = 1'b0;
    w_neg = 1'b0;
    w_err = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = w_sum;
        w_ov  = (src0[WIDTH-1] == src1[WIDTH-1]) && (w_sum[WIDTH-1] != src0[WIDTH-1]);
        w_neg = w_sum[WIDTH-1];
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ov  = (src0[WIDTH-1] != src1[WIDTH-1]) && (w_diff[WIDTH-1] != src0[WIDTH-1]);
        w_neg = w_diff[WIDTH-1];
      end
      OP_AND:  w_res = src0 & src1;
      OP_NOR:  w_res = ~(src0 | src1);
      OP_SLL:  w_res = src0 << shamt;
      OP_SRL:  w_res = src0 >> shamt;
      OP_SRA:  w_res = w_sra;
      OP_MUL:  w_err = (MUL_EN == 0);
      OP_LHB:  w_res = {src1[H-1:0], src0[H-1:0]};
      OP_LLB:  w_res = {{(WIDTH-H){src1[H-1]}}, src1[H-1:0]};
      default: w_err = 1'b1;
    endcase
    w_zr = !w_err && (w_res == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state and handshake outputs; in_ready in DONE follows out_ready so a
  // consumer draining a result can hand in the next request in the same cycle.
  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) begin
          w_stateNext = w_isMul ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (w_mulLast) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (w_accept) begin
            w_stateNext = w_isMul ? BUSY : DONE;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst    <= '0;
      r_ov     <= 1'b0;
      r_zr     <= 1'b0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      if (w_isMul) begin
        r_acc    <= '0;
        r_mcand  <= src0;
        r_mplier <= src1;
        r_cnt    <= '0;
      end else begin
        r_dst <= w_res;
        r_ov  <= w_ov;
        r_zr  <= w_zr;
        r_neg <= w_neg;
        r_err <= w_err;
      end
    end else if (r_state == BUSY) begin
      // One multiplier bit per cycle; the final bit's sum is published directly.
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_mulLast) begin
        r_dst <= w_accNext;
        r_ov  <= 1'b0;
        r_zr  <= (w_accNext == '0);
        r_neg <= 1'b0;
        r_err <= 1'b0;
      end
    end
  end

endmodule
